// File: rtl/conv_kxk_multi_if.sv
// rtl/conv_kxk_multi_if.sv - pixel/weight inputs and result outputs of the KxK convolution engine
interface conv_kxk_multi_if #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int KSIZE     = 5,
  parameter int CHANNELS  = 6
);
  logic                                     en;
  logic [CHANNELS*BIT_WIDTH-1:0]            next;
  logic [CHANNELS*KSIZE*KSIZE*BIT_WIDTH-1:0] filter;
  logic [BIT_WIDTH-1:0]                     bias;
  logic [OUT_WIDTH-1:0]                     convValue;
  logic                                     out_valid;
  logic                                     frame_done;

  modport master (output en, next, filter, bias, input convValue, out_valid, frame_done);
  modport slave  (input en, next, filter, bias, output convValue, out_valid, frame_done);
endinterface

// File: rtl/conv_kxk_multi.sv
// rtl/conv_kxk_multi.sv - streaming multi-channel KxK convolution with line buffers,
// 3-stage product/sum/output pipeline, optional ReLU and saturation
module conv_kxk_multi #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int MAP_SIZE  = 14,
  parameter int KSIZE     = 5,
  parameter int CHANNELS  = 6,
  parameter int RELU      = 0,
  parameter int SATURATE  = 1
) (
  input logic              clk,
  input logic              rst,
  conv_kxk_multi_if.slave  bus
);
  localparam int KK   = KSIZE * KSIZE;
  localparam int WLEN = (KSIZE - 1) * MAP_SIZE + KSIZE;
  localparam int PW   = 2 * BIT_WIDTH;
  localparam int ACC  = PW + $clog2(CHANNELS * KK) + 1;
  localparam int CW   = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
  localparam int EW   = (ACC > OUT_WIDTH) ? ACC : OUT_WIDTH;
  localparam logic signed [EW-1:0] SMAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic win_q, win_d, last_q, last_d;
  logic v1_q, v1_d, f1_q, f1_d, v2_q, v2_d, f2_q, f2_d;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [OUT_WIDTH-1:0] conv_q, conv_d;

  logic signed [BIT_WIDTH-1:0] buf_q  [CHANNELS][WLEN];
  logic signed [BIT_WIDTH-1:0] buf_d  [CHANNELS][WLEN];
  logic signed [PW-1:0]        prod_q [CHANNELS][KK];
  logic signed [PW-1:0]        prod_d [CHANNELS][KK];
  logic signed [ACC-1:0]       csum_q [CHANNELS];
  logic signed [ACC-1:0]       csum_d [CHANNELS];
  logic signed [ACC-1:0]       total;
  logic signed [EW-1:0]        ext;

  // win/last mark the pixel accepted this cycle; they form stage 0 of the valid pipeline
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    win_d  = 1'b0;
    last_d = 1'b0;
    if (bus.en) begin
      win_d  = (row_q >= CW'(KSIZE - 1)) && (col_q >= CW'(KSIZE - 1));
      last_d = (row_q == CW'(MAP_SIZE - 1)) && (col_q == CW'(MAP_SIZE - 1));
      if (col_q == CW'(MAP_SIZE - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(MAP_SIZE - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    buf_d = buf_q;
    if (bus.en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        buf_d[c][0] = bus.next[c*BIT_WIDTH +: BIT_WIDTH];
        for (int i = 1; i < WLEN; i++) buf_d[c][i] = buf_q[c][i-1];
      end
    end
  end

  // Entry 0 is the newest pixel, i.e. the window's bottom-right tap
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int k = 0; k < KSIZE; k++) begin
          prod_d[c][r*KSIZE+k] = buf_q[c][(KSIZE-1-r)*MAP_SIZE + (KSIZE-1-k)]
                               * $signed(bus.filter[(c*KK + r*KSIZE + k)*BIT_WIDTH +: BIT_WIDTH]);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      csum_d[c] = '0;
      for (int t = 0; t < KK; t++) csum_d[c] = csum_d[c] + ACC'(prod_q[c][t]);
    end
  end

  always_comb begin
    total = ACC'($signed(bus.bias));
    for (int c = 0; c < CHANNELS; c++) total = total + csum_q[c];
    if (RELU != 0 && total < 0) total = '0;
    ext  = EW'(total);
    conv_d = conv_q;
    if (v2_q) begin
      if (SATURATE != 0 && ext > SMAX)      conv_d = SMAX[OUT_WIDTH-1:0];
      else if (SATURATE != 0 && ext < SMIN) conv_d = SMIN[OUT_WIDTH-1:0];
      else                                  conv_d = ext[OUT_WIDTH-1:0];
    end
    v1_d         = win_q;
    f1_d         = last_q;
    v2_d         = v1_q;
    f2_d         = f1_q;
    out_valid_d  = v2_q;
    frame_done_d = v2_q & f2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= 1'b0;
      last_q       <= 1'b0;
      v1_q         <= 1'b0;
      f1_q         <= 1'b0;
      v2_q         <= 1'b0;
      f2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      conv_q       <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      last_q       <= last_d;
      v1_q         <= v1_d;
      f1_q         <= f1_d;
      v2_q         <= v2_d;
      f2_q         <= f2_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      conv_q       <= conv_d;
    end
  end

  // Datapath storage needs no reset: every consumer is qualified by a valid bit
  always_ff @(posedge clk) begin
    buf_q  <= buf_d;
    prod_q <= prod_d;
    csum_q <= csum_d;
  end

  assign bus.convValue  = conv_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_kxk_multi.sv
// tb/tb_conv_kxk_multi.sv - table-driven and randomized checks of conv_kxk_multi
// across four output configurations driven by one shared stimulus
module tb_conv_kxk_multi;
  localparam int BW = 8;
  localparam int M  = 14;
  localparam int K  = 5;
  localparam int CH = 6;
  localparam int KK = K * K;
  localparam int NO = M - K + 1;
  localparam int NW = NO * NO;
  localparam int NCASE = 8;

  typedef struct {
    int     pmode;   // 0 constant, 1 ramp r*8+c, 2 random
    int     pval;
    int     wmode;   // 0 constant, 1 identity (ch0 centre tap), 2 random
    int     wval;
    int     bias;
    int     gap;     // percent of cycles with en low
    bit     has_const;
    longint ex [4];
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [CH*BW-1:0]    nxt;
  logic [CH*KK*BW-1:0] filt;
  logic [BW-1:0]       bias_v;

  always #5 clk = ~clk;

  conv_kxk_multi_if #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .KSIZE(K), .CHANNELS(CH)) if0 ();
  conv_kxk_multi_if #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .KSIZE(K), .CHANNELS(CH)) if1 ();
  conv_kxk_multi_if #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .KSIZE(K), .CHANNELS(CH)) if2 ();
  conv_kxk_multi_if #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .KSIZE(K), .CHANNELS(CH)) if3 ();

  assign if0.en = en; assign if0.next = nxt; assign if0.filter = filt; assign if0.bias = bias_v;
  assign if1.en = en; assign if1.next = nxt; assign if1.filter = filt; assign if1.bias = bias_v;
  assign if2.en = en; assign if2.next = nxt; assign if2.filter = filt; assign if2.bias = bias_v;
  assign if3.en = en; assign if3.next = nxt; assign if3.filter = filt; assign if3.bias = bias_v;

  conv_kxk_multi #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .MAP_SIZE(M), .KSIZE(K), .CHANNELS(CH),
                   .RELU(0), .SATURATE(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  conv_kxk_multi #(.BIT_WIDTH(BW), .OUT_WIDTH(32), .MAP_SIZE(M), .KSIZE(K), .CHANNELS(CH),
                   .RELU(1), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  conv_kxk_multi #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .MAP_SIZE(M), .KSIZE(K), .CHANNELS(CH),
                   .RELU(0), .SATURATE(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  conv_kxk_multi #(.BIT_WIDTH(BW), .OUT_WIDTH(16), .MAP_SIZE(M), .KSIZE(K), .CHANNELS(CH),
                   .RELU(0), .SATURATE(0)) u3 (.clk(clk), .rst(rst), .bus(if3));

  int     n_vec = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     stray_cnt = 0;
  longint got_v [4][$];
  bit     got_f [4][$];
  int     got_c [$];
  int     acc_q [$];
  int     base_v [4];
  int     base_c, acc_base, stray_base;
  int     pix [CH][M][M];
  int     wgt [CH][KK];
  int     cur_bias;
  longint exp_q [$];
  vec_t   vecs [NCASE];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en) acc_q.push_back(cyc + 1);
    if (if0.out_valid) begin
      got_v[0].push_back(longint'($signed(if0.convValue)));
      got_f[0].push_back(if0.frame_done);
      got_c.push_back(cyc);
    end
    if (if1.out_valid) begin
      got_v[1].push_back(longint'($signed(if1.convValue)));
      got_f[1].push_back(if1.frame_done);
    end
    if (if2.out_valid) begin
      got_v[2].push_back(longint'($signed(if2.convValue)));
      got_f[2].push_back(if2.frame_done);
    end
    if (if3.out_valid) begin
      got_v[3].push_back(longint'($signed(if3.convValue)));
      got_f[3].push_back(if3.frame_done);
    end
    if ((if0.frame_done && !if0.out_valid) || (if1.frame_done && !if1.out_valid) ||
        (if2.frame_done && !if2.out_valid) || (if3.frame_done && !if3.out_valid))
      stray_cnt <= stray_cnt + 1;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic longint cur_conv(int d);
    case (d)
      0:       return longint'($signed(if0.convValue));
      1:       return longint'($signed(if1.convValue));
      2:       return longint'($signed(if2.convValue));
      default: return longint'($signed(if3.convValue));
    endcase
  endfunction

  function automatic longint cur_flags(int d);
    case (d)
      0:       return {if0.out_valid, if0.frame_done};
      1:       return {if1.out_valid, if1.frame_done};
      2:       return {if2.out_valid, if2.frame_done};
      default: return {if3.out_valid, if3.frame_done};
    endcase
  endfunction

  // Output stage of each configuration, from exact integer sum
  function automatic longint shape(longint s, int d);
    longint v, hi, lo, m;
    int ow;
    v  = s;
    ow = (d < 2) ? 32 : 16;
    if (d == 1 && v < 0) v = 0;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    if (d != 3) begin
      if (v > hi) v = hi;
      if (v < lo) v = lo;
    end else begin
      m = longint'(1) <<< ow;
      v = v % m;
      if (v < 0) v = v + m;
      if (v > hi) v = v - m;
    end
    return v;
  endfunction

  function automatic vec_t mk(int pm, int pv, int wm, int wv, int b, int g, bit hc,
                              longint e0, longint e1, longint e2, longint e3);
    vec_t v;
    v.pmode = pm; v.pval = pv; v.wmode = wm; v.wval = wv; v.bias = b; v.gap = g;
    v.has_const = hc;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3;
    return v;
  endfunction

  task automatic setup(input vec_t v);
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < M; r++)
        for (int x = 0; x < M; x++)
          pix[c][r][x] = (v.pmode == 0) ? v.pval :
                         (v.pmode == 1) ? r * 8 + x : int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < KK; t++)
        wgt[c][t] = (v.wmode == 0) ? v.wval :
                    (v.wmode == 1) ? ((c == 0 && t == 12) ? 1 : 0) :
                    int'($urandom_range(0, 255)) - 128;
    cur_bias = (v.wmode == 2) ? int'($urandom_range(0, 255)) - 128 : v.bias;
    for (int c = 0; c < CH; c++)
      for (int t = 0; t < KK; t++)
        filt[(c*KK + t)*BW +: BW] = BW'(wgt[c][t]);
    bias_v = BW'(cur_bias);
    exp_q.delete();
    for (int r0 = 0; r0 < NO; r0++)
      for (int c0 = 0; c0 < NO; c0++) begin
        longint s = cur_bias;
        for (int c = 0; c < CH; c++)
          for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++)
              s += longint'(pix[c][r0+r][c0+k]) * longint'(wgt[c][r*K+k]);
        exp_q.push_back(s);
      end
  endtask

  task automatic snap();
    for (int d = 0; d < 4; d++) base_v[d] = got_v[d].size();
    base_c     = got_c.size();
    acc_base   = acc_q.size();
    stray_base = stray_cnt;
  endtask

  // Called at posedge+1; leaves en low at posedge+1 after the last accept
  task automatic send_pixels(input int gap, input int npix);
    int i = 0;
    while (i < npix) begin
      if (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
        en = 1'b0;
      end else begin
        int p = i % (M * M);
        en = 1'b1;
        for (int c = 0; c < CH; c++) nxt[c*BW +: BW] = BW'(pix[c][p / M][p % M]);
        i++;
      end
      @(posedge clk); #1;
    end
    en = 1'b0;
  endtask

  task automatic compare(input string tag, input int nframes, input vec_t v, input bit chk_lat);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s d%0d count", tag, d), got_v[d].size() - base_v[d], nframes * NW);
      for (int i = 0; i < nframes * NW; i++) begin
        if (base_v[d] + i < got_v[d].size()) begin
          int w = i % NW;
          longint g = got_v[d][base_v[d] + i];
          chk($sformatf("%s d%0d val[%0d]", tag, d, i), g, shape(exp_q[w], d));
          chk($sformatf("%s d%0d frame_done[%0d]", tag, d, i),
              longint'(got_f[d][base_v[d] + i]), longint'(w == NW - 1));
          if (v.has_const)
            chk($sformatf("%s d%0d const[%0d]", tag, d, i), g, v.ex[d]);
          if (v.pmode == 1 && v.wmode == 1)
            chk($sformatf("%s d%0d ident[%0d]", tag, d, i), g,
                shape(longint'(((w / NO) + 2) * 8 + (w % NO) + 2 + 3), d));
        end
      end
    end
    chk({tag, " stray frame_done"}, stray_cnt - stray_base, 0);
    if (chk_lat) begin
      if (got_c.size() > base_c && acc_q.size() > acc_base + 60)
        chk({tag, " latency"}, got_c[base_c] - acc_q[acc_base + 60], 3);
      else
        chk({tag, " latency sample missing"}, 0, 1);
    end
  endtask

  initial begin
    vecs[0] = mk(0,    1, 0,    1, 0,  0, 1, 150, 150, 150, 150);
    vecs[1] = mk(1,    0, 1,    0, 3,  0, 0, 0, 0, 0, 0);
    vecs[2] = mk(0,    1, 0,   -1, 5,  0, 1, -145, 0, -145, -145);
    vecs[3] = mk(0, -128, 0, -128, 0,  0, 1, 2457600, 2457600, 32767, -32768);
    vecs[4] = mk(0,    1, 0,    1, 0, 40, 1, 150, 150, 150, 150);
    vecs[5] = mk(1,    0, 1,    0, 3, 40, 0, 0, 0, 0, 0);
    vecs[6] = mk(2,    0, 2,    0, 0, 30, 0, 0, 0, 0, 0);
    vecs[7] = mk(2,    0, 2,    0, 0,  0, 0, 0, 0, 0, 0);

    rst = 1'b1; en = 1'b0; nxt = '0; filt = '0; bias_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset d%0d convValue", d), cur_conv(d), 0);
      chk($sformatf("reset d%0d valid/done", d), cur_flags(d), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < NCASE; k++) begin
      setup(vecs[k]);
      repeat (2) @(posedge clk); #1;
      snap();
      send_pixels(vecs[k].gap, M * M);
      repeat (8) @(posedge clk); #1;
      compare($sformatf("case%0d", k), 1, vecs[k], k == 0);
    end

    // Abort a frame after 80 pixels, then two back-to-back frames
    setup(vecs[1]);
    repeat (2) @(posedge clk); #1;
    send_pixels(0, 80);
    rst = 1'b1;
    snap();
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("midreset d%0d convValue", d), cur_conv(d), 0);
      chk($sformatf("midreset d%0d valid/done", d), cur_flags(d), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_pixels(0, 2 * M * M);
    repeat (8) @(posedge clk); #1;
    compare("reset2frames", 2, vecs[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_kxk_multi.md
# conv_kxk_multi

Parameterised streaming multi-channel KxK convolution engine for the LeNet-5 datapath. It accepts one pixel per input channel per enabled cycle in raster order and keeps its own per-channel line buffers. It emits one bias-added sum per valid output position, tagged with `out_valid`, and flags the end of each frame. Optional ReLU and saturation are applied on the output. It sits between a feature-map source (input image or pooling layer) and the next pooling or fully connected stage.

## Interface
- `BIT_WIDTH`, 8, signed width of pixels, weights and bias
- `OUT_WIDTH`, 32, signed width of `convValue`
- `MAP_SIZE`, 14, input map is MAP_SIZE x MAP_SIZE per channel
- `KSIZE`, 5, filter is KSIZE x KSIZE per channel; requires 1 <= KSIZE <= MAP_SIZE
- `CHANNELS`, 6, number of input channels summed into one output
- `RELU`, 0, 1 = clamp negative results to 0
- `SATURATE`, 1, 1 = saturate to OUT_WIDTH; 0 = keep the low OUT_WIDTH bits

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  pixel strobe; when high, one pixel per channel is accepted this cycle
- `next`  in  CHANNELS*BIT_WIDTH  signed pixels; channel c occupies bits [(c+1)*BIT_WIDTH-1 : c*BIT_WIDTH]
- `filter`  in  CHANNELS*KSIZE*KSIZE*BIT_WIDTH  signed weights
  - channel c occupies slice c*KSIZE*KSIZE
  - within a channel, tap index is r*KSIZE+k, with tap 0 at the window top-left
- `bias`  in  BIT_WIDTH  signed bias, added as an integer (no shift)
- `convValue`  out  OUT_WIDTH  signed result
- `out_valid`  out  1  one-cycle strobe; `convValue` holds a new result
- `frame_done`  out  1  asserted together with the `out_valid` of the last window of a frame

## Operation
- **Window buffer:** each channel has a shift register of (KSIZE-1)*MAP_SIZE+KSIZE entries. It shifts in `next` only when `en`=1.
- **Position counters:** `col` counts 0..MAP_SIZE-1 on each `en`. On wrap, `row` increments 0..MAP_SIZE-1. After (MAP_SIZE-1, MAP_SIZE-1), both wrap to 0 and the next frame starts with no gap.
- **Window-valid rule:** an accepted pixel at (row, col) completes a window iff row >= KSIZE-1 and col >= KSIZE-1.
  - Windows that span a row wrap are never marked valid.
  - Each frame yields exactly (MAP_SIZE-KSIZE+1)^2 results (100 at defaults).
- **Pipeline:** free-running, 3 stages, each carrying a valid bit.
  - S1: register all CHANNELS*KSIZE*KSIZE products, each 2*BIT_WIDTH signed.
  - S2: register the per-channel sums.
  - S3: sum across channels, add sign-extended `bias`, apply ReLU then saturate/truncate, and register into `convValue` / `out_valid` / `frame_done`.
- **Internal width:** ACC = 2*BIT_WIDTH + clog2(CHANNELS*KSIZE*KSIZE) + 1. No overflow is allowed before S3.
- **Saturation:** with SATURATE=1, values above 2^(OUT_WIDTH-1)-1 clamp to that maximum, and values below -2^(OUT_WIDTH-1) clamp to that minimum. If ACC <= OUT_WIDTH, the result is sign-extended instead.
- **Operand stability:** `filter` and `bias` must be stable for the whole frame. They are sampled in S1 and S3 respectively.
- **Output hold:** `convValue` holds its last result while `out_valid`=0.

## Timing
- **Reset values:** `convValue`=0, `out_valid`=0, `frame_done`=0. Counters and pipeline valid bits also clear to 0. Clearing the buffer contents is not required.
- **Latency:** `out_valid` rises exactly 3 clock edges after the edge that accepts a window-completing pixel.
- **`en` low:** counters and buffers hold; in-flight pipeline results still drain and appear on time.
- **Throughput:** one result per cycle when `en` is held high across valid columns.
- **Reset mid-frame:** takes effect immediately.
  - All in-flight results are discarded and no `out_valid` is produced from them.
  - The next accepted pixel is (0,0) of a new frame.
- **Frame boundary:** `frame_done` is high only with the result for window (MAP_SIZE-1, MAP_SIZE-1). The next frame's first pixel may be accepted on the following cycle.

## Test plan
- **All ones:** defaults, all pixels=1, all weights=1, bias=0, `en` held high.
  - 100 `out_valid` pulses, each with `convValue`=150.
  - First pulse 3 cycles after the 61st accepted pixel.
  - `frame_done` only on the 100th pulse.
- **Identity filter:** only ch0 centre tap =1, pixel(r,c)=r*8+c on every channel, bias=3.
  - The result for the window whose top-left is (r,c) equals (r+2)*8+c+2+3, in raster order.
- **ReLU:** all weights=-1, pixels=1, bias=5.
  - RELU=0 gives -145 on every output.
  - RELU=1 gives 0 on every output.
- **Saturation:** OUT_WIDTH=16, all weights=-128, pixels=-128, bias=0.
  - SATURATE=1 gives 32767.
  - SATURATE=0 gives -32768, the truncation of 2457600.
- **Random `en` gaps:** the all-ones and identity cases repeated with `en` randomly low about 40% of cycles.
  - Identical value sequence, exactly 100 results per frame.
- **Reset mid-frame:** assert `rst` after 80 pixels, then stream two full frames back-to-back.
  - No output from the aborted frame.
  - 200 correct results.
  - Two `frame_done` pulses.
